// File: rtl/usb_reply_arbiter_pkg.sv
// Shared definitions for the USB reply arbiter and the command interface.
package usb_reply_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  localparam int unsigned TAG_BYTE_W = 8;

  // Bit positions of the tag byte (the MS byte of a reply word).
  function automatic int unsigned tag_msb(input int unsigned reply_bytes);
    return reply_bytes * 8 - 1;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned reply_bytes);
    return reply_bytes * 8 - TAG_BYTE_W;
  endfunction

endpackage

// File: rtl/usb_reply_arbiter_rr_pick.sv
// Round-robin priority picker: first set bit of pending scanning upward from ptr.
module usb_reply_arbiter_rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    pending,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            found
);

  // Scan ptr, ptr+1, ..., N-1, 0, ..., ptr-1 and keep the first pending index.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!found && pending[ID_W'(idx)]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_reply_arbiter.sv
// Round-robin arbiter sharing the single USB reply port among N_REQ requesters,
// each with a one-entry holding slot.
module usb_reply_arbiter
  import usb_reply_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned REPLY_BYTES = 4,
  parameter int unsigned TAG_REPLIES = 1,
  parameter int unsigned ID_W        = $clog2(N_REQ)
) (
  input  logic                           CLK_48,
  input  logic                           RESET_N,
  input  logic [N_REQ-1:0]               i_req,
  input  logic [N_REQ*REPLY_BYTES*8-1:0] i_req_data,
  output logic [N_REQ-1:0]               o_req_ready,
  input  logic                           i_busy,
  output logic                           o_reply,
  output logic [REPLY_BYTES*8-1:0]       o_data,
  output logic [ID_W-1:0]                o_grant_id,
  output logic [N_REQ-1:0]               o_pending
);

  localparam int unsigned DW      = REPLY_BYTES * 8;
  localparam int unsigned TAG_MSB = tag_msb(REPLY_BYTES);
  localparam int unsigned TAG_LSB = tag_lsb(REPLY_BYTES);

  arb_state_t       state;
  logic [DW-1:0]    slot_data [N_REQ];
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] ready;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] grant_mask;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  ptr_next;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             do_grant;
  logic [DW-1:0]    win_word;

  usb_reply_arbiter_rr_pick #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .pending (pending),
    .ptr     (ptr),
    .winner  (winner),
    .found   (found)
  );

  assign accept      = i_req & ready;
  assign do_grant    = (state == IDLE) && found && !i_busy;
  assign ptr_next    = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
  assign o_req_ready = ready;
  assign o_pending   = pending;

  // One-hot mask of the slot being granted this cycle.
  always_comb begin
    grant_mask = '0;
    if (do_grant) grant_mask[winner] = 1'b1;
  end

  // Winning slot's word, with the source index stamped into the MS byte if enabled.
  always_comb begin
    win_word = slot_data[winner];
    if (TAG_REPLIES != 0) win_word[TAG_MSB:TAG_LSB] = TAG_BYTE_W'(winner);
  end

  // Slot storage: latch a requester's word when its slot accepts.
  always_ff @(posedge CLK_48) begin
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (accept[k]) slot_data[k] <= i_req_data[k*DW +: DW];
    end
  end

  // Slot bookkeeping and IDLE/ISSUE FSM with registered reply outputs.
  // ready follows the pre-edge pending state, so a granted slot stays
  // not-ready for one extra edge and cannot be refilled while being granted.
  always_ff @(posedge CLK_48 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      ptr        <= '0;
      pending    <= '0;
      ready      <= '0;
      o_reply    <= 1'b0;
      o_data     <= '0;
      o_grant_id <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | accept;
      ready   <= ~pending & ~accept;
      case (state)
        IDLE: begin
          if (do_grant) begin
            state      <= ISSUE;
            o_reply    <= 1'b1;
            o_data     <= win_word;
            o_grant_id <= winner;
            ptr        <= ptr_next;
          end
        end
        ISSUE: begin
          state   <= IDLE;
          o_reply <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          o_reply <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_reply_arbiter.sv
// Self-checking bench for usb_reply_arbiter (N_REQ=4, REPLY_BYTES=4, tagging on).
module tb_usb_reply_arbiter;

  logic        CLK_48;
  logic        RESET_N;
  logic [3:0]  i_req;
  logic [127:0] i_req_data;
  logic [3:0]  o_req_ready;
  logic        i_busy;
  logic        o_reply;
  logic [31:0] o_data;
  logic [1:0]  o_grant_id;
  logic [3:0]  o_pending;

  int checks = 0;
  int errors = 0;

  usb_reply_arbiter #(
    .N_REQ       (4),
    .REPLY_BYTES (4),
    .TAG_REPLIES (1),
    .ID_W        (2)
  ) dut (
    .CLK_48      (CLK_48),
    .RESET_N     (RESET_N),
    .i_req       (i_req),
    .i_req_data  (i_req_data),
    .o_req_ready (o_req_ready),
    .i_busy      (i_busy),
    .o_reply     (o_reply),
    .o_data      (o_data),
    .o_grant_id  (o_grant_id),
    .o_pending   (o_pending)
  );

  initial CLK_48 = 1'b0;
  always #5 CLK_48 = ~CLK_48;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] word;
    logic        busy;
    logic [3:0]  e_ready;
    logic        e_reply;
    logic [31:0] e_data;
    logic [1:0]  e_grant;
    logic [3:0]  e_pend;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock: inputs were driven at a negedge, outputs sampled at the next negedge.
  task automatic step();
    @(posedge CLK_48);
    @(negedge CLK_48);
  endtask

  logic [31:0] lane [4];
  logic [3:0]  mdl_pend;
  logic [31:0] mdl_word [4];
  logic [1:0]  mdl_ptr;
  logic        mdl_issue;

  initial begin
    int posted;
    int served;
    int busy_cnt;
    int w;
    logic [3:0] req_e;
    logic [3:0] rdy_e;
    logic [3:0] acc;
    logic       busy_e;
    logic       exp_reply;

    // Directed vectors, starting right after reset release (ptr=0, all slots free).
    vt[0]  = '{4'b0100, 32'hAABBCCDD, 1'b0, 4'b1011, 1'b0, 32'h00000000, 2'd0, 4'b0100};
    vt[1]  = '{4'b0000, 32'h00000000, 1'b0, 4'b1011, 1'b1, 32'h02BBCCDD, 2'd2, 4'b0000};
    vt[2]  = '{4'b0000, 32'h00000000, 1'b0, 4'b1111, 1'b0, 32'h02BBCCDD, 2'd2, 4'b0000};
    vt[3]  = '{4'b1000, 32'h11223344, 1'b0, 4'b0111, 1'b0, 32'h02BBCCDD, 2'd2, 4'b1000};
    vt[4]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0111, 1'b1, 32'h03223344, 2'd3, 4'b0000};
    vt[5]  = '{4'b0000, 32'h00000000, 1'b0, 4'b1111, 1'b0, 32'h03223344, 2'd3, 4'b0000};
    vt[6]  = '{4'b1111, 32'h55667788, 1'b0, 4'b0000, 1'b0, 32'h03223344, 2'd3, 4'b1111};
    vt[7]  = '{4'b0000, 32'h00000000, 1'b0, 4'b0000, 1'b1, 32'h00667788, 2'd0, 4'b1110};
    vt[8]  = '{4'b0001, 32'h99AABBCC, 1'b0, 4'b0001, 1'b0, 32'h00667788, 2'd0, 4'b1110};
    vt[9]  = '{4'b0001, 32'h99AABBCC, 1'b0, 4'b0000, 1'b1, 32'h01667788, 2'd1, 4'b1101};
    vt[10] = '{4'b0000, 32'h00000000, 1'b0, 4'b0010, 1'b0, 32'h01667788, 2'd1, 4'b1101};
    vt[11] = '{4'b0000, 32'h00000000, 1'b0, 4'b0010, 1'b1, 32'h02667788, 2'd2, 4'b1001};
    vt[12] = '{4'b0000, 32'h00000000, 1'b0, 4'b0110, 1'b0, 32'h02667788, 2'd2, 4'b1001};
    vt[13] = '{4'b0000, 32'h00000000, 1'b0, 4'b0110, 1'b1, 32'h03667788, 2'd3, 4'b0001};
    vt[14] = '{4'b0000, 32'h00000000, 1'b0, 4'b1110, 1'b0, 32'h03667788, 2'd3, 4'b0001};
    vt[15] = '{4'b0000, 32'h00000000, 1'b0, 4'b1110, 1'b1, 32'h00AABBCC, 2'd0, 4'b0000};
    vt[16] = '{4'b0000, 32'h00000000, 1'b0, 4'b1111, 1'b0, 32'h00AABBCC, 2'd0, 4'b0000};

    // Reset held with all requesters asserting.
    RESET_N    = 1'b0;
    i_req      = 4'b1111;
    i_req_data = {4{32'hDEADBEEF}};
    i_busy     = 1'b0;
    @(negedge CLK_48);
    step();
    step();
    chk("rst_ready", 32'(o_req_ready), 32'h0);
    chk("rst_reply", 32'(o_reply), 32'h0);
    chk("rst_pending", 32'(o_pending), 32'h0);
    chk("rst_data", o_data, 32'h0);
    chk("rst_grant", 32'(o_grant_id), 32'h0);
    RESET_N = 1'b1;
    step();
    chk("rel_ready", 32'(o_req_ready), 32'hF);
    chk("rel_pending", 32'(o_pending), 32'h0);
    i_req = 4'b0000;

    // Table: single request, contention from ptr=0, reload of slot 0.
    for (int i = 0; i < 17; i++) begin
      i_req      = vt[i].req;
      i_req_data = {4{vt[i].word}};
      i_busy     = vt[i].busy;
      step();
      chk($sformatf("v%0d_ready", i), 32'(o_req_ready), 32'(vt[i].e_ready));
      chk($sformatf("v%0d_reply", i), 32'(o_reply), 32'(vt[i].e_reply));
      chk($sformatf("v%0d_data", i), o_data, vt[i].e_data);
      chk($sformatf("v%0d_grant", i), 32'(o_grant_id), 32'(vt[i].e_grant));
      chk($sformatf("v%0d_pending", i), 32'(o_pending), 32'(vt[i].e_pend));
    end

    // Backpressure: slots 1 and 3 pending while busy; ptr is 1 here.
    i_req      = 4'b1010;
    i_req_data = {4{32'h12345678}};
    i_busy     = 1'b1;
    step();
    chk("bp_load_pending", 32'(o_pending), 32'hA);
    chk("bp_load_ready", 32'(o_req_ready), 32'h5);
    i_req = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_hold_reply", 32'(o_reply), 32'h0);
      chk("bp_hold_pending", 32'(o_pending), 32'hA);
    end
    i_busy = 1'b0;
    step();
    chk("bp_g1_reply", 32'(o_reply), 32'h1);
    chk("bp_g1_grant", 32'(o_grant_id), 32'h1);
    chk("bp_g1_data", o_data, 32'h01345678);
    step();
    chk("bp_gap_reply", 32'(o_reply), 32'h0);
    step();
    chk("bp_g3_reply", 32'(o_reply), 32'h1);
    chk("bp_g3_grant", 32'(o_grant_id), 32'h3);
    chk("bp_g3_data", o_data, 32'h03345678);
    step();
    chk("bp_end_reply", 32'(o_reply), 32'h0);
    chk("bp_end_pending", 32'(o_pending), 32'h0);

    // Command-interface model: busy for 3 edges after each strobe, 100 random posts.
    mdl_pend  = 4'b0000;
    mdl_ptr   = 2'd0;
    mdl_issue = 1'b0;
    posted    = 0;
    served    = 0;
    busy_cnt  = 0;
    for (int k = 0; k < 4; k++) begin
      lane[k]     = 32'h0;
      mdl_word[k] = 32'h0;
    end
    for (int cyc = 0; cyc < 4000 && served < 100; cyc++) begin
      req_e  = i_req;
      rdy_e  = o_req_ready;
      busy_e = i_busy;
      step();
      exp_reply = !mdl_issue && (mdl_pend != 4'b0000) && !busy_e;
      chk("cif_reply", 32'(o_reply), 32'(exp_reply));
      if (o_reply && busy_e) chk("cif_reply_while_busy", 32'(o_reply), 32'h0);
      if (exp_reply) begin
        w = -1;
        for (int i = 0; i < 4; i++) begin
          if (w < 0 && mdl_pend[(int'(mdl_ptr) + i) % 4]) w = (int'(mdl_ptr) + i) % 4;
        end
        chk("cif_grant", 32'(o_grant_id), 32'(w));
        chk("cif_data", o_data, {8'(w), mdl_word[w][23:0]});
        mdl_pend[w] = 1'b0;
        mdl_ptr     = 2'((w + 1) % 4);
        served++;
      end
      mdl_issue = exp_reply;
      acc = req_e & rdy_e;
      for (int k = 0; k < 4; k++) begin
        if (acc[k]) begin
          mdl_pend[k] = 1'b1;
          mdl_word[k] = lane[k];
          i_req[k]    = 1'b0;
        end
      end
      if (o_reply) begin
        busy_cnt = 2;
        i_busy   = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        i_busy = 1'b1;
      end else begin
        i_busy = 1'b0;
      end
      for (int k = 0; k < 4; k++) begin
        if (!i_req[k] && posted < 100 && $urandom_range(0, 2) == 0) begin
          lane[k]  = $urandom;
          i_req[k] = 1'b1;
          posted++;
        end
      end
      i_req_data = {lane[3], lane[2], lane[1], lane[0]};
    end
    chk("cif_served", 32'(served), 32'd100);

    // Drain before the reset test.
    i_req  = 4'b0000;
    i_busy = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("drain_pending", 32'(o_pending), 32'h0);
    chk("drain_ready", 32'(o_req_ready), 32'hF);

    // Reset asserted during ISSUE with 3 slots still pending.
    i_req      = 4'b1111;
    i_req_data = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
    step();
    i_req = 4'b0000;
    step();
    chk("mid_issue_reply", 32'(o_reply), 32'h1);
    chk("mid_issue_count", 32'($countones(o_pending)), 32'd3);
    RESET_N = 1'b0;
    #1;
    chk("async_reply", 32'(o_reply), 32'h0);
    chk("async_pending", 32'(o_pending), 32'h0);
    chk("async_ready", 32'(o_req_ready), 32'h0);
    @(negedge CLK_48);
    RESET_N = 1'b1;
    step();
    chk("rel2_ready", 32'(o_req_ready), 32'hF);
    i_req = 4'b1111;
    step();
    i_req = 4'b0000;
    step();
    chk("ptr_reset_reply", 32'(o_reply), 32'h1);
    chk("ptr_reset_grant", 32'(o_grant_id), 32'h0);
    chk("ptr_reset_data", o_data, 32'h00DE0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_reply_arbiter.md
# usb_reply_arbiter

Round-robin arbiter that lets several command-handling blocks share the single reply port of the USB command interface. Each requester has a one-entry holding slot, so a requester can post a reply and continue without waiting for the shared port. The arbiter forwards one reply at a time to the reply port and obeys that port's busy/overflow backpressure. It can optionally stamp the source index into the first byte transmitted.

## Interface
Parameters:
- N_REQ, 4 — number of requesters, 2..16
- REPLY_BYTES, 4 — reply width in bytes; must match the USB command interface
- TAG_REPLIES, 1 — when 1, the MS byte of the forwarded reply is replaced by the source index, zero-extended to 8 bits
- ID_W, $clog2(N_REQ) — width of the grant index

Ports:
- CLK_48  in  1  — 48 MHz system clock; all logic on its rising edge
- RESET_N  in  1  — asynchronous, active-low reset
- i_req  in  N_REQ  — per-requester valid
- i_req_data  in  N_REQ*REPLY_BYTES*8  — flattened reply words; requester k occupies bits [k*REPLY_BYTES*8 +: REPLY_BYTES*8]
- o_req_ready  out  N_REQ  — per-requester slot free; registered
- i_busy  in  1  — reply port busy; connect to the command interface overflow output
- o_reply  out  1  — one-cycle reply strobe to the command interface
- o_data  out  REPLY_BYTES*8  — reply word; valid while o_reply=1
- o_grant_id  out  ID_W  — source index of the last issued reply
- o_pending  out  N_REQ  — slot-occupied flags; status and debug

## Operation
- Slot k accepts a word on the rising edge where i_req[k] and o_req_ready[k] are both 1.
  - pending[k] is set and the word is latched.
  - o_req_ready[k] falls on the same edge.
- i_req[k] while o_req_ready[k]=0 is ignored. The requester must hold the word; no data is dropped silently.
- FSM states: IDLE, ISSUE.
- IDLE transition to ISSUE occurs when |pending and !i_busy. On that edge the arbiter:
  - selects winner w, the first pending index scanning ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1;
  - loads o_data from slot w (tag applied if TAG_REPLIES);
  - sets o_reply=1 and o_grant_id=w;
  - clears pending[w] and sets ptr = (w+1) mod N_REQ.
- ISSUE transitions to IDLE unconditionally on the next edge, with o_reply=0. This guard cycle covers i_busy lagging the strobe by one cycle.
- o_req_ready[k] returns to 1 on the edge after pending[k] clears. A slot cannot be refilled on the same edge it is granted.
- ptr wraps from N_REQ-1 to 0. ptr changes only on a grant.
- o_data holds its last value outside ISSUE.

## Timing
- Reset values (async assert while RESET_N=0):
  - state IDLE, ptr 0, pending 0, o_pending 0;
  - o_reply 0, o_data 0, o_grant_id 0, o_req_ready 0.
- o_req_ready becomes all-ones on the first rising edge after RESET_N deasserts.
- Latency from accept to o_reply, with i_busy=0 and no contention: accept at edge E0, grant at E1, o_reply high during the cycle after E1. Minimum 2 edges.
- Throughput is at most one reply per 2 cycles. With the real command interface, i_busy additionally stalls for REPLY_BYTES-1 cycles per reply.
- Simultaneous accept into slot k and grant of slot j≠k: both take effect.
- A word accepted on edge E cannot be granted before edge E+1.
- i_busy is sampled only in IDLE. i_busy=1 freezes the grant; pending slots and ptr are retained.
- Fairness: with all slots continuously pending, each index is granted once per N_REQ grants.
- Reset asserted mid-ISSUE: o_reply drops immediately and all pending words are discarded. Requesters must treat reset as a flush.

## Structure
- A shared package holds the arbiter state encoding (IDLE=0, ISSUE=1) and the tag-byte position constant (bit REPLY_BYTES*8-1 down to REPLY_BYTES*8-8). The command interface uses the same constant.
- The round-robin priority picker (pending vector + ptr → winner index + found flag) is a natural combinational sub-module: rr_pick.
- Slot storage is registers, N_REQ × REPLY_BYTES*8 bits; no RAM.

## Test plan
- Reset sequence:
  - Stimulus: hold RESET_N low with i_req=4'b1111.
  - Required: o_req_ready=0, o_reply=0, nothing accepted.
  - After release, o_req_ready=4'b1111 on the first edge.
- Single request:
  - Stimulus: N_REQ=4, TAG_REPLIES=1, i_busy=0; requester 2 posts 32'hAABBCCDD.
  - Required: o_reply pulses for exactly 1 cycle, 2 edges later, with o_data=32'h02BBCCDD and o_grant_id=2.
  - o_req_ready[2] low for 2 cycles, then returns to 1.
- Contention:
  - Stimulus: all 4 slots loaded on the same edge, ptr=0, i_busy=0.
  - Required: grants in order 0,1,2,3, one strobe every 2 cycles.
  - Reload slot 0 after its grant: it is served after 3.
- Backpressure:
  - Stimulus: slots 1 and 3 pending, i_busy held high for 20 cycles.
  - Required: no o_reply, pending=4'b1010 stays stable.
  - After i_busy drops, reply from slot 1 is issued, then slot 3.
- Command-interface model:
  - Stimulus: i_busy driven high for REPLY_BYTES-1 cycles starting 1 cycle after each o_reply; 100 random requests.
  - Required: every posted word appears exactly once, in round-robin order among contenders.
  - No o_reply while i_busy=1.
- Reset mid-operation:
  - Stimulus: assert RESET_N low during ISSUE with 3 slots pending.
  - Required: o_reply drops asynchronously, o_pending=0, ptr=0 after release.
